// File: rtl/ifu_fetch.sv
// ifu_fetch: npc fetch initiator; owns pc, keeps one imem read outstanding, hands {pc,inst} to decode.
// Latency: out_valid two cycles after request acceptance (3 cycles/inst with zero-wait memory).
// Backpressure: request held until mem_req_ready, {pc,inst} held until out_ready. Option: IFU_MISALIGN_CHK_EN.
module ifu_fetch #(
  parameter int                ADDR_W = 32,
  parameter int                INST_W = 32,
  parameter logic [ADDR_W-1:0] RST_PC = 32'h80000000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [INST_W-1:0] mem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst
`ifdef IFU_MISALIGN_CHK_EN
  , output logic            out_misaligned
`endif
);

  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

  state_e            stateQ, stateD;
  logic [ADDR_W-1:0] pcQ, redirTgt;
  logic [INST_W-1:0] instQ;
  logic              dropQ, misQ, redirMis, reqFire;

`ifdef IFU_MISALIGN_CHK_EN
  localparam logic [INST_W-1:0] NopInst = INST_W'(32'h00000013);
  assign redirTgt = redirect_pc;
  assign redirMis = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign redirTgt = redirect_pc & ~ADDR_W'(3);
  assign redirMis = 1'b0;
`endif

  assign reqFire = mem_req_valid && mem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) stateQ <= StReq;
    else     stateQ <= stateD;
  end

  // misQ marks a pc reached by a misaligned redirect: HOLD then shows a nop instead of fetching.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StReq: begin
        if (reqFire)       stateD = StWait;
        else if (redirMis) stateD = StHold;
      end
      StWait: begin
        if (mem_rsp_valid) begin
          if (dropQ || redirect_valid)
            stateD = (redirect_valid ? redirMis : misQ) ? StHold : StReq;
          else
            stateD = StHold;
        end
      end
      StHold: begin
        if (redirect_valid) stateD = redirMis ? StHold : StReq;
        else if (out_ready) stateD = StReq;
      end
      default: stateD = StReq;
    endcase
  end

  always_comb begin
    mem_req_valid = (stateQ == StReq) && !rst;
    mem_req_addr  = pcQ;
    out_valid     = (stateQ == StHold);
    out_pc        = pcQ;
`ifdef IFU_MISALIGN_CHK_EN
    out_inst       = misQ ? NopInst : instQ;
    out_misaligned = (stateQ == StHold) && misQ;
`else
    out_inst      = instQ;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcQ   <= RST_PC;
      dropQ <= 1'b0;
      instQ <= '0;
      misQ  <= 1'b0;
    end else begin
      case (stateQ)
        StReq: begin
          if (redirect_valid) begin
            pcQ  <= redirTgt;
            misQ <= redirMis;
            if (reqFire) dropQ <= 1'b1;
          end
        end
        StWait: begin
          if (mem_rsp_valid) begin
            if (dropQ || redirect_valid) begin
              dropQ <= 1'b0;
              if (redirect_valid) begin
                pcQ  <= redirTgt;
                misQ <= redirMis;
              end
            end else begin
              instQ <= mem_rsp_data;
            end
          end else if (redirect_valid) begin
            pcQ   <= redirTgt;
            misQ  <= redirMis;
            dropQ <= 1'b1;
          end
        end
        StHold: begin
          if (redirect_valid) begin
            pcQ  <= redirTgt;
            misQ <= redirMis;
          end else if (out_ready) begin
            pcQ  <= pcQ + ADDR_W'(4);
            misQ <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: randomized memory/decode/redirect traffic against a next-pc reference model.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h80000000;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
`ifdef IFU_MISALIGN_CHK_EN
  logic        outMis;
`endif

  always #5 clk = ~clk;

  ifu_fetch #(.ADDR_W(32), .INST_W(32), .RST_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
`ifdef IFU_MISALIGN_CHK_EN
    .out_misaligned(outMis),
`endif
    .out_inst(out_inst)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: the pc that must be fetched/delivered next, plus the memory responder.
  logic [31:0] expPc = RST_PC;
  logic        nopPend = 1'b0;
  logic        inFlight = 1'b0;
  int          lat = 0;
  logic [31:0] rspWord = '0;
  logic        holdReq = 1'b0;
  logic [31:0] holdAddr = '0;
  int          gap = 0, outCount = 0, cyc = 0, lastHs = -1;
  bit          cadenceChk = 1'b0;
  int          pReady = 100, pOut = 100, pRedir = 0, maxLat = 0;
  bit          forceRedir = 1'b0;
  logic [31:0] forceTgt = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579BDF;
  endfunction

  function automatic bit pct(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  function automatic logic [31:0] randTarget();
    logic [31:0] base;
    logic [31:0] low;
    base = ($urandom_range(0, 99) < 5) ? 32'hFFFFFFFC : (32'h80000000 | ($urandom_range(0, 1023) << 2));
`ifdef IFU_MISALIGN_CHK_EN
    low = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 32'd0;
`else
    low = $urandom_range(0, 3);
`endif
    return base | low;
  endfunction

  // One cycle: called just after a negedge; drives inputs for the next posedge and checks outputs.
  task automatic step();
    logic hsReq, hsOut, doRedir, rspNow;
    logic [31:0] tgt;
    cyc++;
    if (holdReq) begin
      check("req_held_vld", 32'(mem_req_valid), 32'd1);
      check("req_held_addr", mem_req_addr, holdAddr);
    end
    rspNow = inFlight && (lat == 0);
    if (inFlight && lat > 0) lat--;
    mem_rsp_valid  = rspNow;
    mem_rsp_data   = rspNow ? rspWord : $urandom();
    mem_req_ready  = pct(pReady);
    out_ready      = pct(pOut);
    doRedir        = forceRedir || pct(pRedir);
    tgt            = forceRedir ? forceTgt : randTarget();
    forceRedir     = 1'b0;
    redirect_valid = doRedir;
    redirect_pc    = tgt;

    hsReq = mem_req_valid && mem_req_ready;
    hsOut = out_valid && out_ready && !doRedir;

    if (out_valid) begin
      check("out_pc", out_pc, expPc);
      check("out_inst", out_inst, nopPend ? NOP : word(expPc));
      check("req_vld_in_hold", 32'(mem_req_valid), 32'd0);
      if (cadenceChk) check("out_latency", 32'(cyc - lastHs), 32'd2);
`ifdef IFU_MISALIGN_CHK_EN
      check("out_misaligned", 32'(outMis), 32'(nopPend));
    end else begin
      check("misaligned_idle", 32'(outMis), 32'd0);
`endif
    end

    if (hsReq) begin
      check("req_addr", mem_req_addr, expPc);
      check("one_outstanding", 32'(inFlight), 32'd0);
      check("no_req_for_misaligned", 32'(nopPend), 32'd0);
      if (cadenceChk && lastHs >= 0) check("req_cadence", 32'(cyc - lastHs), 32'd3);
      lastHs = cyc;
    end

    if (rspNow) inFlight = 1'b0;
    if (hsReq) begin
      inFlight = 1'b1;
      lat      = $urandom_range(0, maxLat);
      rspWord  = word(mem_req_addr);
    end

    if (doRedir) begin
`ifdef IFU_MISALIGN_CHK_EN
      expPc   = tgt;
      nopPend = (tgt[1:0] != 2'b00);
`else
      expPc   = tgt & ~32'd3;
`endif
    end else if (hsOut) begin
      expPc   = expPc + 32'd4;
      nopPend = 1'b0;
    end

    holdReq  = mem_req_valid && !mem_req_ready && !doRedir;
    holdAddr = mem_req_addr;

    if (hsOut) begin
      gap = 0;
      outCount++;
    end else begin
      gap++;
      if (gap == 400) check("progress_gap", 32'(gap), 32'd0);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      @(negedge clk);
    end
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    #1;
    check("rst_req_vld_forced", 32'(mem_req_valid), 32'd0);
    repeat (n) begin
      @(negedge clk);
      check("rst_req_vld", 32'(mem_req_valid), 32'd0);
      check("rst_out_vld", 32'(out_valid), 32'd0);
      check("rst_out_pc", out_pc, RST_PC);
      check("rst_out_inst", out_inst, 32'd0);
`ifdef IFU_MISALIGN_CHK_EN
      check("rst_misaligned", 32'(outMis), 32'd0);
`endif
    end
    rst = 1'b0;
    #1;
    expPc = RST_PC; nopPend = 1'b0; inFlight = 1'b0; lat = 0;
    holdReq = 1'b0; gap = 0; lastHs = -1;
  endtask

  initial begin
    cadenceChk = 1'b1;
    doReset(3);
    run(15);
    cadenceChk = 1'b0;

    pReady = 0;   run(4);
    pReady = 100; run(6);
    pOut = 0;     run(8);
    pOut = 100;   run(4);

`ifdef IFU_MISALIGN_CHK_EN
    forceTgt = 32'h80000102;
`else
    forceTgt = 32'h80000103;
`endif
    forceRedir = 1'b1;
    run(12);

    pReady = 60; pOut = 60; pRedir = 5; maxLat = 3;
    run(3000);

    doReset(2);
    pReady = 50; pOut = 70; pRedir = 4; maxLat = 2;
    run(1500);

    check("instr_count_min", 32'(outCount > 200), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
